// File: rtl/sram_ctrl_if.sv
// MEM-stage request/response bus between the pipeline and sram_ctrl.
// The MEM stage (master) holds a request stable until ready returns high.
interface sram_ctrl_if;
  logic        MEMread;
  logic        MEMwrite;
  logic [31:0] address;
  logic [31:0] data;
  logic [31:0] MEM_result;
  logic        ready;

  // Pipeline side: issues requests and consumes results.
  modport master (
    output MEMread,
    output MEMwrite,
    output address,
    output data,
    input  MEM_result,
    input  ready
  );

  // Controller side: accepts requests and returns the read word.
  modport slave (
    input  MEMread,
    input  MEMwrite,
    input  address,
    input  data,
    output MEM_result,
    output ready
  );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: MEM-stage responder for a 16-bit asynchronous SRAM.
// Each 32-bit request becomes two half-word accesses (low half first). Each
// access lasts WAIT_CYCLES cycles. While an access is in flight, ready is
// low and the pipeline freezes. All SRAM pins are registered. The outputs
// for a cycle are therefore set at the edge that enters that cycle.
module sram_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic         clk,
  input  logic         reset,
  sram_ctrl_if.slave   mem_bus,
  inout  wire  [15:0]  SRAM_DQ,
  output logic [17:0]  SRAM_ADDR,
  output logic         SRAM_WE_N,
  output logic         SRAM_OE_N
);

  localparam int             CW   = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_write;      // latched operation: 1 = write, 0 = read
  logic [16:0]    r_word_idx;   // latched SRAM word index
  logic [31:0]    r_data_q;     // latched write data
  logic [31:0]    r_mem_result;
  logic [17:0]    r_addr;
  logic           r_we_n;
  logic           r_oe_n;
  logic           r_dq_oe;      // controller drives SRAM_DQ
  logic [15:0]    r_dq_out;

  logic           w_req;
  logic           w_ready;
  logic [16:0]    w_word_idx;
  logic [CW-1:0]  w_cnt_nxt;
  logic           w_we_low_nxt;

  // Offsets outside the SRAM wrap modulo 2^17 words. The truncating cast
  // keeps bits [18:2] of the byte offset.
  assign w_word_idx = 17'((mem_bus.address - BASE_ADDR) >> 2);
  assign w_req      = mem_bus.MEMread | mem_bus.MEMwrite;
  assign w_cnt_nxt  = r_cnt + 1'b1;

  // WE_N is low for every cycle of a half-word write except the last one.
  // The last cycle is write recovery, so address and data can move safely
  // afterwards.
  assign w_we_low_nxt = r_write && (w_cnt_nxt != LAST);

  // In IDLE, ready is combinational so an idle pipeline sees no latency.
  assign w_ready = (r_state == S_IDLE) ? ~w_req : (r_state == S_DONE);

  assign mem_bus.ready      = w_ready;
  assign mem_bus.MEM_result = r_mem_result;
  assign SRAM_ADDR          = r_addr;
  assign SRAM_WE_N          = r_we_n;
  assign SRAM_OE_N          = r_oe_n;
  assign SRAM_DQ            = r_dq_oe ? r_dq_out : 16'hzzzz;

  // Access sequencer: state, wait counter, SRAM pins and read-data capture.
  // NOTE: every register here uses non-blocking assignment. The next-state
  // terms (w_cnt_nxt, r_data_q, ...) then read pre-edge values, and the
  // statement order inside the block cannot change the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_word_idx   <= '0;
      r_data_q     <= '0;
      r_mem_result <= '0;
      r_addr       <= '0;
      r_we_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_dq_oe      <= 1'b0;
      r_dq_out     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            // If both enables are high, the write takes precedence.
            r_state    <= S_LOW;
            r_cnt      <= '0;
            r_write    <= mem_bus.MEMwrite;
            r_word_idx <= w_word_idx;
            r_data_q   <= mem_bus.data;
            r_addr     <= {w_word_idx, 1'b0};
            // WAIT_CYCLES >= 2, so cnt 0 is never the recovery cycle.
            r_we_n     <= ~mem_bus.MEMwrite;
            r_oe_n     <= mem_bus.MEMwrite;
            r_dq_oe    <= mem_bus.MEMwrite;
            r_dq_out   <= mem_bus.data[15:0];
          end
        end

        S_LOW: begin
          if (r_cnt == LAST) begin
            if (!r_write) begin
              r_mem_result[15:0] <= SRAM_DQ;
            end
            r_state  <= S_HIGH;
            r_cnt    <= '0;
            r_addr   <= {r_word_idx, 1'b1};
            r_we_n   <= ~r_write;
            r_dq_out <= r_data_q[31:16];
          end else begin
            r_cnt  <= w_cnt_nxt;
            r_we_n <= ~w_we_low_nxt;
          end
        end

        S_HIGH: begin
          if (r_cnt == LAST) begin
            if (!r_write) begin
              r_mem_result[31:16] <= SRAM_DQ;
            end
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_dq_oe <= 1'b0;
          end else begin
            r_cnt  <= w_cnt_nxt;
            r_we_n <= ~w_we_low_nxt;
          end
        end

        S_DONE: begin
          // The pipeline advances on this edge. Any request seen in the
          // next IDLE cycle is a new one.
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: directed steps plus randomized read/write traffic.
// Results are checked against a word-level memory model and a behavioural
// async-SRAM model. The SRAM model commits a half-word only after a WE_N
// low pulse that is followed by a recovery cycle at the same address.
module tb_sram_ctrl;

  localparam logic [31:0] BASE  = 32'd1024;
  localparam logic [31:0] WRAP4 = 32'd524288;  // 4 * 2^17 bytes

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_ctrl_if bus2();
  sram_ctrl_if bus3();

  wire  [15:0] dq2, dq3;
  logic [17:0] addr2, addr3;
  logic        we2_n, oe2_n, we3_n, oe3_n;

  sram_ctrl #(.WAIT_CYCLES(2), .BASE_ADDR(BASE)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .mem_bus   (bus2),
    .SRAM_DQ   (dq2),
    .SRAM_ADDR (addr2),
    .SRAM_WE_N (we2_n),
    .SRAM_OE_N (oe2_n)
  );

  sram_ctrl #(.WAIT_CYCLES(3), .BASE_ADDR(BASE)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .mem_bus   (bus3),
    .SRAM_DQ   (dq3),
    .SRAM_ADDR (addr3),
    .SRAM_WE_N (we3_n),
    .SRAM_OE_N (oe3_n)
  );

  // Power-up contents of a half-word that has never been written.
  function automatic logic [15:0] init_pat(input logic [17:0] h);
    return 16'(h) * 16'h9E37 + 16'h1234;
  endfunction

  // ---------------- SRAM models ----------------
  bit   [15:0] mem2 [0:262143];
  bit          wr2  [0:262143];
  logic [15:0] rd2;
  logic        pend_v = 1'b0;
  logic [17:0] pend_a = '0;
  logic [15:0] pend_d = '0;

  always_comb rd2 = wr2[addr2] ? mem2[addr2] : init_pat(addr2);
  assign dq2 = (!oe2_n) ? rd2 : 16'hzzzz;
  assign dq3 = (!oe3_n) ? init_pat(addr3) : 16'hzzzz;

  // Write pulse capture; commit once WE_N returns high at the same address.
  always @(posedge clk) begin
    if (!we2_n) begin
      pend_v <= 1'b1;
      pend_a <= addr2;
      pend_d <= dq2;
    end else begin
      if (pend_v && addr2 == pend_a) begin
        mem2[pend_a] <= pend_d;
        wr2[pend_a]  <= 1'b1;
      end
      pend_v <= 1'b0;
    end
  end

  function automatic logic [15:0] mem_half(input int h);
    return wr2[h] ? mem2[h] : init_pat(18'(h));
  endfunction

  // ---------------- pin monitor ----------------
  int   oe_falls2 = 0, we_falls2 = 0, oe_falls3 = 0, we_falls3 = 0;
  logic prev_oe2 = 1'b1, prev_we2 = 1'b1, prev_oe3 = 1'b1, prev_we3 = 1'b1;
  logic overlap = 1'b0;

  always @(negedge clk) begin
    if ((!we2_n && !oe2_n) || (!we3_n && !oe3_n)) overlap <= 1'b1;
    if (prev_oe2 && !oe2_n) oe_falls2 <= oe_falls2 + 1;
    if (prev_we2 && !we2_n) we_falls2 <= we_falls2 + 1;
    if (prev_oe3 && !oe3_n) oe_falls3 <= oe_falls3 + 1;
    if (prev_we3 && !we3_n) we_falls3 <= we_falls3 + 1;
    prev_oe2 <= oe2_n;
    prev_we2 <= we2_n;
    prev_oe3 <= oe3_n;
    prev_we3 <= we3_n;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) / 32'd4) % 32'd131072);
  endfunction

  function automatic logic [31:0] exp_word(input int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return {init_pat(18'(2 * w + 1)), init_pat(18'(2 * w))};
  endfunction

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input int w);
    logic [31:0] e;
    e = exp_word(w);
    check({tag, "_lo"}, {16'h0, mem_half(2 * w)},     {16'h0, e[15:0]});
    check({tag, "_hi"}, {16'h0, mem_half(2 * w + 1)}, {16'h0, e[31:16]});
  endtask

  // One request on the W=2 controller, held until ready. address/data are
  // scrambled after IDLE to show they are sampled only at the request.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int lows, output logic [31:0] res);
    @(negedge clk);
    bus2.MEMread  = rd;
    bus2.MEMwrite = wr;
    bus2.address  = a;
    bus2.data     = d;
    #1;
    lows = 0;
    while (bus2.ready !== 1'b1 && lows < 50) begin
      lows++;
      @(negedge clk);
      bus2.address = $urandom;
      bus2.data    = $urandom;
      #1;
    end
    res = bus2.MEM_result;
    bus2.MEMread  = 1'b0;
    bus2.MEMwrite = 1'b0;
  endtask

  initial begin
    int          lows, w, op, cyc, idx, f0;
    logic [31:0] a, d, res, exp_result, tmp;
    logic [31:0] reqs [2];
    logic [31:0] got  [2];

    bus2.MEMread = 1'b0; bus2.MEMwrite = 1'b0; bus2.address = '0; bus2.data = '0;
    bus3.MEMread = 1'b0; bus3.MEMwrite = 1'b0; bus3.address = '0; bus3.data = '0;
    exp_result = '0;

    // Reset for 3 cycles, then idle.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("rst_ready",  {31'h0, bus2.ready}, 32'd1);
    check("rst_we_n",   {31'h0, we2_n},      32'd1);
    check("rst_oe_n",   {31'h0, oe2_n},      32'd1);
    check("rst_addr",   {14'h0, addr2},      32'd0);
    check("rst_result", bus2.MEM_result,     32'd0);
    check("rst_ready3", {31'h0, bus3.ready}, 32'd1);
    n_vec++;
    assert (dq2 === 16'hzzzz) else begin
      n_err++;
      $error("FAIL rst_dq_hiz: observed 0x%04h, expected zzzz", dq2);
    end

    // Write 0xDEADBEEF to 1028, then read it back.
    f0 = we_falls2;
    do_req(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, lows, res);
    ref_mem[widx(32'd1028)] = 32'hDEADBEEF;
    check("wr_ready_low", lows, 32'd5);
    check("wr_result_hold", res, exp_result);
    check("wr_hw2", {16'h0, mem_half(2)}, 32'h0000BEEF);
    check("wr_hw3", {16'h0, mem_half(3)}, 32'h0000DEAD);
    check("wr_pulses", we_falls2 - f0, 32'd2);
    n_vec++;
    assert (dq2 === 16'hzzzz) else begin
      n_err++;
      $error("FAIL done_dq_hiz: observed 0x%04h, expected zzzz", dq2);
    end

    do_req(1'b1, 1'b0, 32'd1028, 32'h0, lows, res);
    exp_result = exp_word(widx(32'd1028));
    check("rd_ready_low", lows, 32'd5);
    check("rd_result", res, exp_result);

    // Both enables high: behaves as a write.
    f0 = oe_falls2;
    do_req(1'b1, 1'b1, 32'd1024, 32'h12345678, lows, res);
    ref_mem[widx(32'd1024)] = 32'h12345678;
    check("both_ready_low", lows, 32'd5);
    check("both_hw0", {16'h0, mem_half(0)}, 32'h00005678);
    check("both_hw1", {16'h0, mem_half(1)}, 32'h00001234);
    check("both_result_hold", res, exp_result);
    check("both_no_read", oe_falls2 - f0, 32'd0);

    // Stalling pipeline: read 1024, then 1032, advancing only on ready.
    reqs[0] = 32'd1024;
    reqs[1] = 32'd1032;
    f0  = oe_falls2;
    idx = 0;
    cyc = 0;
    while (idx < 2 && cyc < 100) begin
      @(negedge clk);
      bus2.MEMread = 1'b1;
      bus2.address = reqs[idx];
      #1;
      cyc++;
      if (bus2.ready === 1'b1) begin
        got[idx] = bus2.MEM_result;
        idx++;
      end
    end
    bus2.MEMread = 1'b0;
    check("b2b_done", idx, 32'd2);
    check("b2b_res0", got[0], exp_word(widx(reqs[0])));
    check("b2b_res1", got[1], exp_word(widx(reqs[1])));
    check("b2b_accesses", oe_falls2 - f0, 32'd2);
    check("b2b_cycles", cyc, 32'd12);
    exp_result = exp_word(widx(reqs[1]));

    // Randomized traffic over a small window, sometimes via a wrapped alias.
    for (int k = 0; k < 24; k++) begin
      w  = $urandom_range(0, 15);
      a  = BASE + 32'(4 * w) + (($urandom_range(0, 3) == 0) ? WRAP4 : 32'd0);
      d  = $urandom;
      op = $urandom_range(0, 2);
      do_req(op != 1, op != 0, a, d, lows, res);
      check("rnd_ready_low", lows, 32'd5);
      if (op == 0) begin
        exp_result = exp_word(widx(a));
        check("rnd_read", res, exp_result);
      end else begin
        ref_mem[widx(a)] = d;
        check("rnd_wr_hold", res, exp_result);
        check_word("rnd_wr", widx(a));
      end
    end

    // Reset lands while the high half of a write to 1040 is being driven.
    tmp = exp_word(widx(32'd1040));
    @(negedge clk);
    bus2.MEMwrite = 1'b1;
    bus2.address  = 32'd1040;
    bus2.data     = 32'hAAAA5555;
    repeat (3) @(negedge clk);
    #1;
    check("mid_we_low", {31'h0, we2_n}, 32'd0);
    check("mid_addr", {14'h0, addr2}, 32'd9);
    reset = 1'b1;
    @(negedge clk);
    reset         = 1'b0;
    bus2.MEMwrite = 1'b0;
    #1;
    check("abort_we_n",   {31'h0, we2_n},      32'd1);
    check("abort_ready",  {31'h0, bus2.ready}, 32'd1);
    check("abort_result", bus2.MEM_result,     32'd0);
    ref_mem[widx(32'd1040)] = {tmp[31:16], 16'h5555};
    @(negedge clk);
    check("abort_hw8", {16'h0, mem_half(8)}, 32'h00005555);
    check("abort_hw9", {16'h0, mem_half(9)}, {16'h0, tmp[31:16]});

    // Wrapped address on the W=3 controller maps to half-words 0 and 1.
    @(negedge clk);
    bus3.MEMread = 1'b1;
    bus3.address = BASE + WRAP4;
    #1;
    lows = 0;
    while (bus3.ready !== 1'b1 && lows < 50) begin
      lows++;
      @(negedge clk);
      #1;
    end
    res = bus3.MEM_result;
    bus3.MEMread = 1'b0;
    check("w3_ready_low", lows, 32'd7);
    check("w3_wrap_read", res, {init_pat(18'd1), init_pat(18'd0)});
    check("w3_accesses", oe_falls3, 32'd1);
    check("w3_no_write", we_falls3, 32'd0);

    @(negedge clk);
    check("we_oe_overlap", {31'h0, overlap}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Memory-side responder for the ARM pipeline's MEM stage. It accepts one 32-bit word read or write per request from the MEM stage and performs it on an external 16-bit asynchronous SRAM as two half-word accesses. While an access is in progress it holds `ready` low; the top level uses `~ready` to freeze every pipeline register. Because each request takes several cycles, the MEM stage's request is held stable until `ready` returns high.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: cycles spent on each half-word access. Legal range is 2 or more.
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `MEMread` in 1: read request from the MEM stage.
- `MEMwrite` in 1: write request from the MEM stage.
- `address` in 32: byte address of the request (ALU result).
- `data` in 32: write data (Val_Rm).
- `MEM_result` out 32: read data, registered.
- `ready` out 1: high means the MEM stage may advance; low means freeze the pipeline.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_WE_N` out 1: SRAM write enable, active-low.
- `SRAM_OE_N` out 1: SRAM output enable, active-low.

## Operation
Address mapping:
- `word_idx = (address - BASE_ADDR)[18:2]`, 17 bits.
- Out-of-range addresses wrap modulo 2^17 words. There is no error indication.
- Low half is `SRAM_ADDR = {word_idx, 1'b0}`; high half is `{word_idx, 1'b1}`.

State machine states: IDLE, LOW, HIGH, DONE. There is a counter `cnt` with range 0..WAIT_CYCLES-1.
- **IDLE**
  - `ready = ~(MEMread | MEMwrite)`.
  - On a request: latch `word_idx`, `data` and the operation. Write wins if both enables are high. Set `cnt=0` and go to LOW.
- **LOW**
  - `SRAM_ADDR` = low-half address.
  - Write: drive `SRAM_DQ = data_q[15:0]`; `SRAM_WE_N = 0` for cnt 0..WAIT_CYCLES-2 and 1 on the last cycle (write recovery).
  - Read: `SRAM_OE_N = 0` and `SRAM_DQ` is high-Z. On the last cycle, capture `SRAM_DQ` into `MEM_result[15:0]`.
  - `cnt` increments each cycle. At `cnt == WAIT_CYCLES-1`, clear `cnt` and go to HIGH.
- **HIGH**: identical to LOW, using the high-half address and `data_q[31:16]` / `MEM_result[31:16]`. At `cnt == WAIT_CYCLES-1`, go to DONE.
- **DONE**
  - `ready = 1`; `MEM_result` holds the full word.
  - Next state is IDLE unconditionally. The pipeline advances on this edge, so any request seen in the next IDLE is a new instruction. The same request is never re-issued.
- `ready = 0` in LOW and HIGH.
- Outside write cycles `SRAM_DQ` is high-Z. `SRAM_WE_N` and `SRAM_OE_N` are never low at the same time.
- `MEM_result` is updated only by reads. It holds its last value across writes and idle cycles.
- `address` and `data` are sampled only in IDLE. Changes to them during LOW, HIGH or DONE are ignored.

## Timing
- The request is seen in IDLE at cycle 0.
  - LOW occupies cycles 1..W.
  - HIGH occupies cycles W+1..2W.
  - DONE is cycle 2W+1.
  - With W = WAIT_CYCLES, `ready` is low for 2W+1 cycles (cycles 0..2W) and high in cycle 2W+1.
- Default W=2: a request at cycle 0 gives `ready` high at cycle 5. Back-to-back requests take 6 cycles each.
- With no request, `ready` is high every cycle and there is zero latency.
- Reset values:
  - state IDLE, `cnt` 0, `MEM_result` 0.
  - `SRAM_WE_N` 1, `SRAM_OE_N` 1, `SRAM_ADDR` 0, `SRAM_DQ` high-Z.
  - `ready` follows the IDLE rule.
- Reset mid-operation aborts the access: the next cycle is IDLE with `SRAM_WE_N` high. A write aborted after LOW leaves only the low half written; this is accepted.
- `SRAM_ADDR` and `SRAM_DQ` change only on cycles where `SRAM_WE_N` is 1 at the preceding edge.

## Test plan
- **Reset and idle:** hold `reset` for 3 cycles, then idle.
  - Expect `ready=1`, `SRAM_WE_N=1`, `SRAM_OE_N=1`, `SRAM_DQ` high-Z and `MEM_result=0`.
- **Write then read:** write `0xDEADBEEF` to address 1028, then read 1028.
  - Write: SRAM half-word 2 = `0xBEEF`, half-word 3 = `0xDEAD`.
  - Read: `MEM_result=0xDEADBEEF` in the DONE cycle.
  - `ready` is low for exactly 5 cycles per request with W=2.
- **Simultaneous enables:** assert `MEMread` and `MEMwrite` together with `data=0x12345678` at address 1024.
  - The operation is a write: half-words 0 and 1 become `0x5678` and `0x1234`.
  - `MEM_result` is unchanged.
- **Back-to-back with stall:** a pipeline model freezes on `~ready` and issues a read of 1024 followed by a read of 1032.
  - Exactly two SRAM accesses occur; there is no duplicate.
  - `MEM_result` values arrive in order.
- **Reset mid-write:** assert `reset` during HIGH of a write of `0xAAAA5555` to 1040.
  - Half-word 8 = `0x5555`; half-word 9 is unchanged.
  - The next cycle is IDLE with `SRAM_WE_N=1`.
- **Address wrap and WAIT_CYCLES=3:** read at address `1024 + 4*2^17`.
  - It accesses SRAM half-words 0 and 1.
  - `ready` is low for 7 cycles.
